// File: rtl/program_sequencer.sv
// program_sequencer: program counter with a loadable program memory,
// jump/call/return flow control, a return-address stack and halt detection.
// The instruction output always holds the memory word at the current count,
// fetched on the same edge that moves the count.
module program_sequencer #(
  parameter int                         COUNTER_WIDTH = 4,
  parameter int                         WIDTH         = 8,
  parameter logic [COUNTER_WIDTH-1:0]   RESET_VECTOR  = '0,
  parameter int                         STACK_DEPTH   = 4,
  parameter logic [WIDTH-1:0]           HALT_OPCODE   = '1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     enable,
  input  logic                     jump_valid,
  input  logic [COUNTER_WIDTH-1:0] jump_target,
  input  logic                     call_valid,
  input  logic                     ret_valid,
  input  logic                     load_valid,
  input  logic [COUNTER_WIDTH-1:0] load_addr,
  input  logic [WIDTH-1:0]         load_data,
  output logic [COUNTER_WIDTH-1:0] count,
  output logic [WIDTH-1:0]         instruction,
  output logic                     instr_valid,
  output logic                     halted,
  output logic                     error
);

  localparam int MEM_DEPTH     = 2 ** COUNTER_WIDTH;
  // Stack pointer must be able to hold STACK_DEPTH itself (the "full" value).
  localparam int SP_W          = $clog2(STACK_DEPTH + 1);
  // Array sized to the full pointer range so any pointer value is a legal index;
  // only entries 0..STACK_DEPTH-1 are ever written.
  localparam int STACK_ENTRIES = 2 ** SP_W;
  localparam logic [SP_W-1:0] STACK_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALTED
  } state_t;

  state_t                   r_state;
  logic [COUNTER_WIDTH-1:0] r_count;
  logic [WIDTH-1:0]         r_instruction;
  logic                     r_instr_valid;
  logic                     r_halted;
  logic                     r_error;
  logic [SP_W-1:0]          r_sp;

  logic [WIDTH-1:0]         r_mem   [MEM_DEPTH];
  logic [COUNTER_WIDTH-1:0] r_stack [STACK_ENTRIES];

  logic [COUNTER_WIDTH-1:0] w_next;
  logic [COUNTER_WIDTH-1:0] w_ret_addr;
  logic [SP_W-1:0]          w_sp_top;
  logic [WIDTH-1:0]         w_next_word;
  logic [WIDTH-1:0]         w_rv_word;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_fault;
  logic                     w_advance;

  assign w_ret_addr  = r_count + 1'b1;
  assign w_sp_top    = r_sp - 1'b1;
  // Both reads see the pre-edge memory, so a same-edge write returns old data.
  assign w_next_word = r_mem[w_next];
  assign w_rv_word   = r_mem[RESET_VECTOR];

  // Next-address selection while running: ret > call > jump > sequential.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_next    = r_count + 1'b1;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_fault   = 1'b0;
    w_advance = 1'b0;
    if (r_state == ST_RUN && enable) begin
      if (ret_valid) begin
        if (r_sp == '0) begin
          w_fault = 1'b1;
        end else begin
          w_pop  = 1'b1;
          w_next = r_stack[w_sp_top];
        end
      end else if (call_valid) begin
        if (r_sp == STACK_FULL) begin
          w_fault = 1'b1;
        end else begin
          w_push = 1'b1;
          w_next = jump_target;
        end
      end else if (jump_valid) begin
        w_next = jump_target;
      end
      w_advance = !w_fault;
    end
  end

  // Sequencer FSM with registered count, instruction and status outputs.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state       <= ST_IDLE;
      r_count       <= RESET_VECTOR;
      r_instruction <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_error       <= 1'b0;
      r_sp          <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            r_count       <= RESET_VECTOR;
            r_instruction <= w_rv_word;
            r_instr_valid <= 1'b1;
            r_error       <= 1'b0;
            // A restart begins a fresh program, so stale return addresses are dropped.
            r_sp          <= '0;
            if (w_rv_word == HALT_OPCODE) begin
              r_state  <= ST_HALTED;
              r_halted <= 1'b1;
            end else begin
              r_state  <= ST_RUN;
              r_halted <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (w_fault) begin
            // Stack overflow/underflow: freeze count, instruction and pointer.
            r_error  <= 1'b1;
            r_halted <= 1'b1;
            r_state  <= ST_HALTED;
          end else if (w_advance) begin
            r_count       <= w_next;
            r_instruction <= w_next_word;
            if (w_push) r_sp <= r_sp + 1'b1;
            if (w_pop)  r_sp <= r_sp - 1'b1;
            if (w_next_word == HALT_OPCODE) begin
              r_state  <= ST_HALTED;
              r_halted <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Return-address stack storage; the pointer lives in the FSM block.
  always_ff @(posedge clock) begin
    // NOTE: storage arrays are deliberately not reset; only the pointer defines validity.
    if (w_push) r_stack[r_sp] <= w_ret_addr;
  end

  // Program memory write port, active in every state and kept across reset.
  always_ff @(posedge clock) begin
    if (load_valid) r_mem[load_addr] <= load_data;
  end

  assign count       = r_count;
  assign instruction = r_instruction;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;
  assign error       = r_error;

endmodule
